spi_master_ctrl: RTL

//  SPI master transfer engine (mode 0: CPOL=0, CPHA=0), one byte per transaction.

---
 rtl/spi_master_ctrl_pkg.sv | 21 ++
 rtl/spi_master_ctrl_clk_div.sv | 27 ++
 rtl/spi_master_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_pkg.sv
// rtl/spi_master_ctrl_pkg.sv - state encoding, mode constants and width helper for the SPI master
package spi_master_ctrl_pkg;

   // Transfer sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_t;

   // Mode 0: serial clock idles low
   localparam logic SPI_CPOL = 1'b0;

   // Counter width for a count of n states, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_master_ctrl_clk_div.sv
// rtl/spi_master_ctrl_clk_div.sv - half-period divider producing one TICK per CLK_DIV enabled cycles
module spi_master_ctrl_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic CLK,
   input  logic CLR,
   input  logic EN,
   output logic TICK
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   // Count enabled cycles, wrapping to zero on the terminal count
   always_ff @(posedge CLK) begin
      if (CLR) begin
         div_cnt <= '0;
      end else if (EN) begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
   end

   assign TICK = EN && (div_cnt == DIV_LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 byte master; optional SPI_LOOPBACK_EN adds a LOOPBACK input
module spi_master_ctrl
   import spi_master_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8,
   parameter int SS_GAP  = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              START,
   input  logic [DATA_W-1:0] TX_DATA,
   output logic              READY,
   output logic              DONE,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              S_CLK,
   output logic              SS,
   output logic              MOSI,
`ifdef SPI_LOOPBACK_EN
   input  logic              LOOPBACK,
`endif
   input  logic              MISO
);

   localparam int BIT_W = $clog2(2 * DATA_W) + 1;
   localparam int GAP_W = cnt_width(SS_GAP);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP - 1);

   spi_state_t        state;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [BIT_W-1:0]  bit_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              tick;
   logic              div_en;
   logic              div_clr;
   logic              rx_bit;

   // Divider runs only while SS is low; held at zero otherwise so SETUP starts from a clean count
   assign div_en  = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
   assign div_clr = CLR || !div_en;

`ifdef SPI_LOOPBACK_EN
   assign rx_bit = LOOPBACK ? MOSI : MISO;
`else
   assign rx_bit = MISO;
`endif

   spi_master_ctrl_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .CLK  (CLK),
      .CLR  (div_clr),
      .EN   (div_en),
      .TICK (tick)
   );

   // Transfer FSM with registered pin and handshake outputs
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state   <= ST_IDLE;
         READY   <= 1'b1;
         DONE    <= 1'b0;
         RX_DATA <= '0;
         S_CLK   <= SPI_CPOL;
         SS      <= 1'b1;
         MOSI    <= 1'b0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  tx_sr <= TX_DATA;
                  MOSI  <= TX_DATA[DATA_W-1];
                  SS    <= 1'b0;
                  READY <= 1'b0;
                  state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tick) begin
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (tick) begin
                  S_CLK <= ~S_CLK;
                  if (!S_CLK) begin
                     rx_sr   <= {rx_sr[DATA_W-2:0], rx_bit};
                     bit_cnt <= bit_cnt + 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= ST_HOLD;
                  end else begin
                     tx_sr   <= tx_sr << 1;
                     MOSI    <= tx_sr[DATA_W-2];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  RX_DATA <= rx_sr;
                  DONE    <= 1'b1;
                  SS      <= 1'b1;
                  MOSI    <= 1'b0;
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  READY   <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
